// File: rtl/spif_pkg.sv
// Shared definitions for the spif packet routers: packet geometry, router FSM states
// and the default-width destination channel mask.
package spif_pkg;

    localparam int PKT_BITS       = 72;
    localparam int KEY_LSB        = 8;
    localparam int ROUTE_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        SEND  = 2'd2
    } router_state_e;

    typedef logic [ROUTE_CHANNELS-1:0] route_mask_t;

endpackage

// File: rtl/pkt_router_mc_if.sv
// Packet stream bundle for pkt_router_mc: one valid/ready input stream and
// NUM_CHANNELS output streams that share a single data word.
interface pkt_router_mc_if #(
    parameter int PACKET_BITS  = spif_pkg::PKT_BITS,
    parameter int NUM_CHANNELS = spif_pkg::ROUTE_CHANNELS
);

    logic [PACKET_BITS-1:0]  pkt_in_data_in;
    logic                    pkt_in_vld_in;
    logic                    pkt_in_rdy_out;
    logic [PACKET_BITS-1:0]  pkt_out_data_out [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pkt_out_vld_out;
    logic [NUM_CHANNELS-1:0] pkt_out_rdy_in;

    // master = traffic source/sink around the router, slave = the router itself
    modport master (
        output pkt_in_data_in,
        output pkt_in_vld_in,
        input  pkt_in_rdy_out,
        input  pkt_out_data_out,
        input  pkt_out_vld_out,
        output pkt_out_rdy_in
    );

    modport slave (
        input  pkt_in_data_in,
        input  pkt_in_vld_in,
        output pkt_in_rdy_out,
        output pkt_out_data_out,
        output pkt_out_vld_out,
        input  pkt_out_rdy_in
    );

endinterface

// File: rtl/pkt_route_match.sv
// Combinational priority matcher: entry i hits when (key & mask[i]) == key[i];
// the lowest-index hit supplies the route.
module pkt_route_match #(
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_ENTRIES  = 16,
    parameter int KEY_BITS     = 32
) (
    input  logic [KEY_BITS-1:0]     key,
    input  logic [KEY_BITS-1:0]     entry_key   [NUM_ENTRIES],
    input  logic [KEY_BITS-1:0]     entry_mask  [NUM_ENTRIES],
    input  logic [NUM_CHANNELS-1:0] entry_route [NUM_ENTRIES],
    output logic                    hit,
    output logic [NUM_CHANNELS-1:0] route
);

    // Scan from the top so the lowest-index hit is the last one written.
    always_comb begin
        hit   = 1'b0;
        route = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if ((key & entry_mask[i]) == entry_key[i]) begin
                hit   = 1'b1;
                route = entry_route[i];
            end
        end
    end

endmodule

// File: rtl/pkt_router_mc.sv
// Multicast packet router: routes each packet to a channel subset chosen by a
// key/mask table, holds it until every destination accepts or the drop timer expires.
module pkt_router_mc #(
    parameter int PACKET_BITS  = spif_pkg::PKT_BITS,
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_ENTRIES  = 16,
    parameter int KEY_BITS     = 32,
    parameter int KEY_LSB      = spif_pkg::KEY_LSB,
    parameter int CNT_BITS     = 32,
    parameter int WAIT_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    pkt_router_mc_if.slave          pkt,
    input  logic [KEY_BITS-1:0]     reg_key_in   [NUM_ENTRIES],
    input  logic [KEY_BITS-1:0]     reg_mask_in  [NUM_ENTRIES],
    input  logic [NUM_CHANNELS-1:0] reg_route_in [NUM_ENTRIES],
    input  logic [WAIT_BITS-1:0]    reg_drop_wait_in,
    output logic [CNT_BITS-1:0]     nomatch_cnt_out,
    output logic [CNT_BITS-1:0]     drop_cnt_out
);

    import spif_pkg::*;

    router_state_e           state_q, state_d;
    logic [PACKET_BITS-1:0]  hold_q, hold_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [WAIT_BITS-1:0]    wait_q, wait_d;
    logic [CNT_BITS-1:0]     nomatch_q, nomatch_d;
    logic [CNT_BITS-1:0]     drop_q, drop_d;

    logic                    match_hit;
    logic [NUM_CHANNELS-1:0] match_route;
    logic [NUM_CHANNELS-1:0] accepted;
    logic [NUM_CHANNELS-1:0] remaining;
    logic                    timeout;
    logic                    in_rdy;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CNT_BITS'(1);
    endfunction

    pkt_route_match #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .NUM_ENTRIES  (NUM_ENTRIES),
        .KEY_BITS     (KEY_BITS)
    ) u_match (
        .key         (hold_q[KEY_LSB +: KEY_BITS]),
        .entry_key   (reg_key_in),
        .entry_mask  (reg_mask_in),
        .entry_route (reg_route_in),
        .hit         (match_hit),
        .route       (match_route)
    );

    // pending is only non-zero in SEND, so it doubles as the output valid vector.
    assign accepted  = pending_q & pkt.pkt_out_rdy_in;
    assign remaining = pending_q & ~pkt.pkt_out_rdy_in;
    assign timeout   = (state_q == SEND) && (reg_drop_wait_in != '0) && (accepted == '0)
                       && (wait_q == reg_drop_wait_in - WAIT_BITS'(1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        wait_d    = wait_q;
        nomatch_d = nomatch_q;
        drop_d    = drop_q;
        in_rdy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (pkt.pkt_in_vld_in) begin
                    hold_d  = pkt.pkt_in_data_in;
                    state_d = MATCH;
                end
            end

            MATCH: begin
                if (!match_hit || (match_route == '0)) begin
                    nomatch_d = sat_inc(nomatch_q);
                    state_d   = IDLE;
                end else begin
                    pending_d = match_route;
                    wait_d    = '0;
                    state_d   = SEND;
                end
            end

            // An accept on the final channels frees the hold register in the same
            // cycle, so the next packet can be captured straight into MATCH.
            SEND: begin
                if (remaining == '0) begin
                    in_rdy    = 1'b1;
                    pending_d = '0;
                    if (pkt.pkt_in_vld_in) begin
                        hold_d  = pkt.pkt_in_data_in;
                        state_d = MATCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    pending_d = '0;
                    drop_d    = sat_inc(drop_q);
                    state_d   = IDLE;
                end else begin
                    pending_d = remaining;
                    wait_d    = (accepted != '0) ? '0 : wait_q + WAIT_BITS'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            pending_q <= '0;
            wait_q    <= '0;
            nomatch_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            nomatch_q <= nomatch_d;
            drop_q    <= drop_d;
        end
    end

    assign pkt.pkt_in_rdy_out  = in_rdy;
    assign pkt.pkt_out_vld_out = pending_q;
    assign nomatch_cnt_out     = nomatch_q;
    assign drop_cnt_out        = drop_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out_data
        assign pkt.pkt_out_data_out[c] = hold_q;
    end

endmodule
